// File: rtl/present_dec_iter.sv
// Iterative PRESENT-80 decryption: forward key schedule to K32, then 31 inverse rounds.
// Ports are declared [N-1:0]; the MSB-first bit 0 of the algorithm is bit N-1 here.
// Optional `PRESENT_DEC_KEYCACHE_EN` keeps the last master key and its K32 so that a repeat key skips KEYEXP.
//
// Handshakes (valid/ready, both sides): a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE. in_valid is ignored in every other state.
// out_valid stays high in DONE until out_ready is seen. out_data is held stable meanwhile.
module present_dec_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    DEC    = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [63:0] SBOX_TBL  = 64'hC56B90AD3EF84712;
  localparam logic [63:0] ISBOX_TBL = 64'h5EF8C12DB463079A;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [5:0] idx;
    idx = {~x, 2'b00};
    return SBOX_TBL[idx +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [5:0] idx;
    idx = {~x, 2'b00};
    return ISBOX_TBL[idx +: 4];
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    return r;
  endfunction

  // P(i) = 16*i mod 63 is a 2-bit rotate of the 6-bit index, so bit j pulls from {j[1:0], j[5:2]}.
  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] r;
    logic [5:0]  jj;
    logic [5:0]  src;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      jj    = 6'(j);
      src   = {jj[1:0], jj[5:2]};
      r[jj] = x[src];
    end
    return r;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ c;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  state_e      state_q, state_d;
  logic [63:0] st_q, st_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] out_q, out_d;
`ifdef PRESENT_DEC_KEYCACHE_EN
  logic [79:0] ckey_q, ckey_d;
  logic [79:0] ck32_q, ck32_d;
  logic        cvld_q, cvld_d;
`endif

  assign in_ready    = (state_q == IDLE) && rst_n;
  assign out_valid   = (state_q == DONE);
  assign out_data    = out_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef PRESENT_DEC_KEYCACHE_EN
    ckey_d  = ckey_q;
    ck32_d  = ck32_q;
    cvld_d  = cvld_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          key_d   = in_key;
          cnt_d   = 5'd1;
          state_d = KEYEXP;
`ifdef PRESENT_DEC_KEYCACHE_EN
          if (cvld_q && (in_key == ckey_q)) begin
            key_d   = ck32_q;
            cnt_d   = 5'd31;
            state_d = DEC;
          end else begin
            // The entry only becomes valid once this key's K32 is actually derived.
            ckey_d = in_key;
            cvld_d = 1'b0;
          end
`endif
        end
      end
      KEYEXP: begin
        key_d = key_fwd(key_q, cnt_q);
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd31;
          state_d = DEC;
`ifdef PRESENT_DEC_KEYCACHE_EN
          ck32_d  = key_d;
          cvld_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DEC: begin
        st_d  = inv_s_layer(inv_p_layer(st_q ^ key_q[79:16]));
        key_d = key_inv(key_q, cnt_q);
        if (cnt_q == 5'd1) state_d = FINAL;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FINAL: begin
        out_d   = st_q ^ key_q[79:16];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
      ckey_q  <= '0;
      ck32_q  <= '0;
      cvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef PRESENT_DEC_KEYCACHE_EN
      ckey_q  <= ckey_d;
      ck32_q  <= ck32_d;
      cvld_q  <= cvld_d;
`endif
    end
  end

endmodule

// File: tb/tb_present_dec_iter.sv
// Bench for present_dec_iter: known answers, randomized requests against a reference decryptor,
// backpressure, busy-time in_valid noise, mid-operation reset and key-cache latency.
module tb_present_dec_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  dbg_state;

  present_dec_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_key      (in_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          n_checks;
  int          n_pass;
  logic [63:0] exp_q[$];
  int          sbox_m[16];
  int          isbox_m[16];
  logic [79:0] mc_key;
  bit          mc_vld;

  function automatic void model_init();
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    for (int v = 0; v < 16; v++) sbox_m[v] = int'(tbl[60-4*v +: 4]);
    for (int v = 0; v < 16; v++) isbox_m[sbox_m[v]] = v;
  endfunction

  // Plain textbook decryption: expand all 32 round keys up front, then peel rounds off in reverse.
  function automatic logic [63:0] model_dec(input logic [63:0] c, input logic [79:0] k);
    logic [63:0] rk[33];
    logic [79:0] r;
    logic [63:0] s;
    logic [63:0] t;
    r = k;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = r[79:16];
      r = {r[18:0], r[79:19]};
      r[79:76] = 4'(sbox_m[r[79:76]]);
      r[19:15] = r[19:15] ^ 5'(i);
    end
    s = c ^ rk[32];
    for (int i = 31; i >= 1; i--) begin
      for (int j = 0; j < 63; j++) t[j] = s[(16*j) % 63];
      t[63] = s[63];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(isbox_m[t[4*n +: 4]]);
      s = s ^ rk[i];
    end
    return s;
  endfunction

  function automatic int exp_latency(input logic [79:0] k);
    int lat;
    lat = 63;
`ifdef PRESENT_DEC_KEYCACHE_EN
    if (mc_vld && (k == mc_key)) lat = 32;
`endif
    mc_key = k;
    mc_vld = 1'b1;
    return lat;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input string tag, input logic [63:0] ct, input logic [79:0] k, input int hold);
    int          lat;
    int          want_lat;
    bit          busy_ok;
    bit          stable;
    logic [63:0] held;
    exp_q.push_back(model_dec(ct, k));
    want_lat  = exp_latency(k);
    out_ready = (hold == 0);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    check({tag, " in_ready_idle"}, 80'(in_ready), 80'(1));
    in_valid = 1'b1;
    in_data  = ct;
    in_key   = k;
    @(posedge clk);
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      in_key   = rand80();
      @(posedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 80'(lat), 80'(want_lat));
    check({tag, " busy_no_ready"}, 80'(busy_ok), 80'(1));
    check({tag, " done_in_ready"}, 80'(in_ready), 80'(0));
    held   = out_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || (out_data !== held) || in_ready) stable = 1'b0;
    end
    if (hold > 0) begin
      check({tag, " hold_stable"}, 80'(stable), 80'(1));
      out_ready = 1'b1;
    end
    check({tag, " out_data"}, 80'(out_data), 80'(exp_q.pop_front()));
    @(posedge clk);
    @(negedge clk);
    check({tag, " post_out_valid"}, 80'(out_valid), 80'(0));
    check({tag, " post_in_ready"}, 80'(in_ready), 80'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [79:0] k;
    n_checks  = 0;
    n_pass    = 0;
    mc_vld    = 1'b0;
    mc_key    = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b1;
    model_init();

    #1;
    check("reset in_ready", 80'(in_ready), 80'(0));
    check("reset out_valid", 80'(out_valid), 80'(0));
    check("reset out_data", 80'(out_data), 80'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release in_ready", 80'(in_ready), 80'(1));

    do_req("kat0", 64'h5579C1387B228445, 80'h0, 0);
    check("kat0 model", 80'(model_dec(64'h5579C1387B228445, 80'h0)), 80'h0);
    do_req("kat1", 64'hE72C46C0F5945049, {80{1'b1}}, 0);
    do_req("kat2", 64'hA112FFC72F68417B, 80'h0, 0);
    check("kat2 model", 80'(model_dec(64'hA112FFC72F68417B, 80'h0)), 80'(64'hFFFFFFFFFFFFFFFF));
    do_req("kat3", 64'h3333DCD3213210D2, {80{1'b1}}, 0);

    do_req("backpressure", {$urandom, $urandom}, rand80(), 10);

    // Abort a decryption 40 cycles after accept; outputs must clear at once.
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    in_key   = rand80();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst_n = 1'b0;
    mc_vld = 1'b0;
    #1;
    check("midreset in_ready", 80'(in_ready), 80'(0));
    check("midreset out_valid", 80'(out_valid), 80'(0));
    check("midreset out_data", 80'(out_data), 80'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req("after_reset", {$urandom, $urandom}, rand80(), 0);

    do_req("cache_a", {$urandom, $urandom}, 80'h0, 0);
    do_req("cache_b", {$urandom, $urandom}, 80'h0, 0);
    do_req("cache_c", {$urandom, $urandom}, {$urandom, $urandom, 16'h1234}, 0);

    k = rand80();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) k = rand80();
      do_req("random", {$urandom, $urandom}, k, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/present_dec_iter.md
# present_dec_iter

Iterative PRESENT-80 decryption core: accepts a 64-bit ciphertext and 80-bit master key over a valid/ready handshake and returns the 64-bit plaintext. Internally it runs the forward key schedule to derive round key K32, then executes 31 inverse rounds, one per clock, unwinding the key schedule alongside. It is the receive-side counterpart to the combinational PRESENT encryption round and shares its bit numbering: MSB-first `[0:63]` / `[0:79]`, where round key = `key[0:63]`.

## Interface
- No parameters; the algorithm is fixed at PRESENT-80, 31 rounds.
- `clk` — input, 1 — rising-edge clock.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `in_valid` — input, 1 — ciphertext and key are valid.
- `in_ready` — output, 1 — core is idle and can accept a request.
- `in_data` — input, `[0:63]` — ciphertext.
- `in_key` — input, `[0:79]` — master key (K1 = `in_key[0:63]`).
- `out_valid` — output, 1 — plaintext is valid.
- `out_ready` — input, 1 — downstream accepts the plaintext.
- `out_data` — output, `[0:63]` — plaintext, registered.

## Operation
- States: `IDLE`, `KEYEXP`, `DEC`, `FINAL`, `DONE`.
- Registers: `st[0:63]`, `key[0:79]`, `cnt[0:4]`.
- `IDLE`:
  - `in_ready` = 1.
  - On `in_valid`: `st <= in_data`, `key <= in_key`, `cnt <= 1`, go to `KEYEXP`.
- `KEYEXP` (forward key update):
  - `key <= fwd(key, cnt)`; `cnt <= cnt + 1`.
  - When the update is applied with `cnt == 31`, `key` holds K32: set `cnt <= 31` and go to `DEC`.
  - `fwd`: rotate left by 61; S-box on `[0:3]`; XOR `cnt` into `[60:64]`.
- `DEC` (one inverse round per cycle):
  - `st <= invS(invP(st ^ key[0:63]))`.
  - `key <= inv(key, cnt)`; `cnt <= cnt - 1`.
  - `inv`: XOR `cnt` into `[60:64]`; inverse S-box on `[0:3]`; rotate right by 61.
  - After the update with `cnt == 1`, `key` = K1: go to `FINAL`.
- `FINAL`: `out_data <= st ^ key[0:63]`; go to `DONE`.
- `DONE`:
  - `out_valid` = 1; `out_data` is held stable.
  - On `out_ready`: go to `IDLE`.
- Handshake rules:
  - `in_ready` is high only in `IDLE`.
  - `in_valid` is ignored in every other state.
  - `out_valid` stays high until it is accepted; there is no drop.
- S-box: C56B90AD3EF84712.
- Inverse S-box: 5EF8C12DB463079A.
- `invP`: output bit `j` = input bit `P(j)`, where `P(i) = 16*i mod 63` for `i < 63` and `P(63) = 63`.
  - Indices here use LSB-numbered PRESENT convention; map them onto the MSB-first vector as `63 - i`.
- Counter arithmetic is 5-bit and never wraps: the range is 1..31 in both directions.

## Timing
- Reset values:
  - `in_ready` = 0 during reset, 1 after reset is released (state `IDLE`).
  - `out_valid` = 0; `out_data` = 0.
  - `st`, `key`, `cnt` = 0; cache is invalid.
- Latency without cache hit: accept on edge E0; `KEYEXP` on edges E1–E31; `DEC` on E32–E62; `FINAL` on E63. `out_valid` is high after E63 and throughout the following cycle.
- Throughput: one block per 64 cycles plus the `DONE` wait.
- Reset asserted mid-operation clears the core immediately; any partial result is discarded.
- `out_ready` held high continuously: `DONE` lasts exactly one cycle; `in_ready` is high on the next cycle.

## Configuration
- `PRESENT_DEC_KEYCACHE_EN` defined:
  - Store the last master key and its K32, plus a valid bit.
  - On accept, if `in_key` equals the stored key and the cache is valid, load `key <= cached K32`, set `cnt <= 31` and go directly to `DEC`. Latency becomes 32 edges (`out_valid` after E32).
  - On a miss, run the full path and write the cache when `KEYEXP` completes.
- Undefined: no cache storage; latency is always 63 edges.

## Test plan
- Known answers, each with `out_ready` = 1 and latency 63 checked exactly:
  - `in_data` = 5579C1387B228445, `in_key` = 0 -> `out_data` = 0000000000000000.
  - `in_data` = E72C46C0F5945049, `in_key` = FFFFFFFFFFFFFFFFFFFF -> `out_data` = 0000000000000000.
  - `in_data` = A112FFC72F68417B, `in_key` = 0 -> `out_data` = FFFFFFFFFFFFFFFF.
  - `in_data` = 3333DCD3213210D2, `in_key` = all ones -> `out_data` = FFFFFFFFFFFFFFFF.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles after `out_valid` rises -> `out_valid` and `out_data` are stable; `in_ready` = 0 throughout.
  - Toggle `in_valid` while the core is busy -> no second accept occurs.
- Reset: assert `rst_n` = 0 at cycle 40 of a decryption -> all outputs are at reset values immediately. A new request after release decrypts correctly.
- Cache, with `PRESENT_DEC_KEYCACHE_EN` defined:
  - Two back-to-back requests with key 0 -> first latency is 63, second is 32; both results are correct.
  - A third request with a different key -> latency 63.
